// File: rtl/ping_sequencer.sv
// Ultrasonic ping sequencer: fires the trigger pulse, runs the measurement window
// timer for the echo-time capture stage, and synchronizes the raw echo line.
module ping_sequencer #(
  parameter int unsigned TIMER_WIDTH   = 13,
  parameter int unsigned TICK_DIV      = 50,
  parameter int unsigned TRIG_TICKS    = 10,
  parameter int unsigned HOLDOFF_TICKS = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   continuous,
  input  logic                   echo_raw,
  output logic                   trig,
  output logic                   echo,
  output logic [TIMER_WIDTH-1:0] timer,
  output logic                   clear,
  output logic                   busy,
  output logic                   window_done
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_TRIGGER = 2'd1;
  localparam logic [1:0] S_LISTEN  = 2'd2;
  localparam logic [1:0] S_HOLDOFF = 2'd3;

  localparam int unsigned PW   = $clog2(TICK_DIV);
  localparam int unsigned CMAX = (TRIG_TICKS > HOLDOFF_TICKS) ? TRIG_TICKS : HOLDOFF_TICKS;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  localparam logic [PW-1:0]          PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0]          TRIG_LAST  = CW'(TRIG_TICKS - 1);
  localparam logic [CW-1:0]          HOLD_LAST  = CW'(HOLDOFF_TICKS - 1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_MAX  = '1;
  localparam logic [TIMER_WIDTH-1:0] TIMER_PEN  = TIMER_MAX - 1'b1;

  logic [1:0]             state_q, state_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic [CW-1:0]          ticks_q, ticks_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic                   trig_q, trig_d;
  logic                   clear_q, clear_d;
  logic                   busy_q, busy_d;
  logic                   window_done_q, window_done_d;
  logic                   sync1_q, sync2_q;
  logic                   tick;

  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    state_d = state_q;
    presc_d = tick ? '0 : presc_q + 1'b1;
    ticks_d = tick ? ticks_q + 1'b1 : ticks_q;
    timer_d = timer_q;

    case (state_q)
      S_IDLE: begin
        presc_d = '0;
        ticks_d = '0;
        timer_d = '0;
        if (start) state_d = S_TRIGGER;
      end
      S_TRIGGER: begin
        if (tick && ticks_q == TRIG_LAST) state_d = S_LISTEN;
      end
      S_LISTEN: begin
        // The step onto TIMER_MAX closes the window, so LISTEN never shows it.
        if (tick) begin
          timer_d = timer_q + 1'b1;
          if (timer_q == TIMER_PEN) state_d = S_HOLDOFF;
        end
      end
      default: begin
        if (tick && ticks_q == HOLD_LAST) begin
          state_d = continuous ? S_TRIGGER : S_IDLE;
          timer_d = '0;
        end
      end
    endcase

    if (state_d != state_q) begin
      presc_d = '0;
      ticks_d = '0;
    end

    // Outputs are registered from the next state so they align with it.
    trig_d        = (state_d == S_TRIGGER);
    clear_d       = (state_d == S_TRIGGER) && (state_q != S_TRIGGER);
    busy_d        = (state_d != S_IDLE);
    window_done_d = (state_d == S_HOLDOFF) && (state_q != S_HOLDOFF);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      presc_q       <= '0;
      ticks_q       <= '0;
      timer_q       <= '0;
      trig_q        <= 1'b0;
      clear_q       <= 1'b0;
      busy_q        <= 1'b0;
      window_done_q <= 1'b0;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      ticks_q       <= ticks_d;
      timer_q       <= timer_d;
      trig_q        <= trig_d;
      clear_q       <= clear_d;
      busy_q        <= busy_d;
      window_done_q <= window_done_d;
      sync1_q       <= echo_raw;
      sync2_q       <= sync1_q;
    end
  end

  assign trig        = trig_q;
  assign echo        = sync2_q;
  assign timer       = timer_q;
  assign clear       = clear_q;
  assign busy        = busy_q;
  assign window_done = window_done_q;

endmodule

// File: tb/tb_ping_sequencer.sv
// Bench for ping_sequencer: ping-offset reference model plus directed scenarios
// with randomized echo, start and continuous activity.
module tb_ping_sequencer;

  localparam int unsigned W = 4;
  localparam int unsigned D = 2;
  localparam int unsigned T = 3;
  localparam int unsigned H = 4;
  localparam int TMAX   = (1 << W) - 1;
  localparam int TD     = T * D;
  localparam int LD     = TMAX * D;
  localparam int HD     = H * D;
  localparam int PERIOD = TD + LD + HD;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         continuous = 1'b0;
  logic         echo_raw = 1'b0;
  logic         trig, echo, clear, busy, window_done;
  logic [W-1:0] timer;

  always #5 clk = ~clk;

  ping_sequencer #(
    .TIMER_WIDTH(W),
    .TICK_DIV(D),
    .TRIG_TICKS(T),
    .HOLDOFF_TICKS(H)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .continuous(continuous),
    .echo_raw(echo_raw),
    .trig(trig),
    .echo(echo),
    .timer(timer),
    .clear(clear),
    .busy(busy),
    .window_done(window_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference: a ping is a sequence of PERIOD cycles indexed by offset m_k.
  bit m_active = 0;
  int m_k = 0;
  bit m_e1 = 0, m_e2 = 0;

  int n_trig, n_clear, n_wd, n_t15, n_idle;
  int rises[$];
  logic prev_trig = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    int e_timer;
    echo_raw = 1'($urandom_range(0, 1));
    @(posedge clk);
    cyc++;
    if (!reset) begin
      m_active = 0; m_k = 0; m_e1 = 0; m_e2 = 0;
    end else begin
      m_e2 = m_e1;
      m_e1 = echo_raw;
      if (!m_active) begin
        if (start) begin m_active = 1; m_k = 0; end
      end else if (m_k == PERIOD - 1) begin
        if (continuous) m_k = 0;
        else m_active = 0;
      end else begin
        m_k++;
      end
    end
    #1;
    if (!m_active)          e_timer = 0;
    else if (m_k < TD)      e_timer = 0;
    else if (m_k < TD + LD) e_timer = (m_k - TD) / D;
    else                    e_timer = TMAX;
    chk("trig",        32'(trig),        32'(m_active && m_k < TD));
    chk("clear",       32'(clear),       32'(m_active && m_k == 0));
    chk("busy",        32'(busy),        32'(m_active));
    chk("window_done", 32'(window_done), 32'(m_active && m_k == TD + LD));
    chk("timer",       32'(timer),       32'(e_timer));
    chk("echo",        32'(echo),        32'(m_e2));
    if (trig) n_trig++;
    if (clear) n_clear++;
    if (window_done) n_wd++;
    if (busy && timer == W'(TMAX)) n_t15++;
    if (!busy) n_idle++;
    if (trig && !prev_trig) rises.push_back(cyc);
    prev_trig = trig;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_timer(input int val, input string tag);
    int n = 0;
    while (timer !== W'(val) && n < 2 * PERIOD) begin
      step();
      n++;
    end
    chk(tag, 32'(timer), 32'(val));
  endtask

  initial begin
    // Reset held, then idle with start low
    reset = 1'b0;
    run(5);
    reset = 1'b1;
    run(20);
    chk("idle_busy", 32'(busy), 32'd0);

    // Single ping
    n_trig = 0; n_clear = 0; n_wd = 0; n_t15 = 0;
    pulse_start();
    run(PERIOD + 4);
    chk("ping_trig_len", 32'(n_trig), 32'd6);
    chk("ping_clear_cnt", 32'(n_clear), 32'd1);
    chk("ping_wd_cnt", 32'(n_wd), 32'd1);
    chk("ping_t15_len", 32'(n_t15), 32'd8);
    chk("ping_end_busy", 32'(busy), 32'd0);

    // Continuous mode, then drop continuous mid-LISTEN
    rises.delete();
    continuous = 1'b1;
    pulse_start();
    run(3 * PERIOD + 1);
    chk("cont_rise_count", 32'(rises.size() >= 3), 32'd1);
    if (rises.size() >= 3) begin
      chk("cont_period_1", 32'(rises[1] - rises[0]), 32'd44);
      chk("cont_period_2", 32'(rises[2] - rises[1]), 32'd44);
    end
    wait_timer(5, "cont_reach_listen");
    continuous = 1'b0;
    run(PERIOD);
    chk("cont_stop_busy", 32'(busy), 32'd0);

    // Start held high through a whole ping: one idle cycle, no extra clears
    n_clear = 0; n_idle = 0;
    start = 1'b1;
    run(PERIOD + 2);
    chk("held_idle_len", 32'(n_idle), 32'd1);
    start = 1'b0;
    run(PERIOD);
    chk("held_clear_cnt", 32'(n_clear), 32'd2);

    // Reset during TRIGGER
    pulse_start();
    run(2);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("rst_trig_trig", 32'(trig), 32'd0);
    run(2);
    n_trig = 0;
    pulse_start();
    run(PERIOD + 2);
    chk("rst_trig_relen", 32'(n_trig), 32'd6);

    // Reset at timer = 7 in LISTEN
    pulse_start();
    wait_timer(7, "rst_listen_reach");
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("rst_listen_timer", 32'(timer), 32'd0);
    run(2);
    n_trig = 0;
    pulse_start();
    run(PERIOD + 2);
    chk("rst_listen_relen", 32'(n_trig), 32'd6);

    // Random mixed activity against the model
    repeat (400) begin
      start      = ($urandom_range(0, 15) == 0);
      continuous = 1'($urandom_range(0, 1));
      reset      = ($urandom_range(0, 99) != 0);
      step();
    end
    reset = 1'b1; start = 1'b0; continuous = 1'b0;
    run(PERIOD + 2);
    chk("final_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
